// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults and counter widths.
package vga_timing_pkg;

    localparam int unsigned CntW      = 10;
    localparam int unsigned FrameCntW = 8;
    localparam int unsigned MaxTotal  = 1 << CntW;

    localparam int unsigned DefTotalCols   = 800;
    localparam int unsigned DefTotalRows   = 525;
    localparam int unsigned DefActiveCols  = 640;
    localparam int unsigned DefActiveRows  = 480;
    localparam int unsigned DefHFrontPorch = 16;
    localparam int unsigned DefHSyncWidth  = 96;
    localparam int unsigned DefVFrontPorch = 10;
    localparam int unsigned DefVSyncWidth  = 2;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Sync/position bundle from the timing generator to the display pipeline.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic                 hsync;
    logic                 vsync;
    logic                 active;
    logic [CntW-1:0]      col_count;
    logic [CntW-1:0]      row_count;
    logic                 line_start;
    logic                 frame_start;
    logic [FrameCntW-1:0] frame_count;

    modport master (
        output hsync, vsync, active, col_count, row_count,
        output line_start, frame_start, frame_count
    );

    modport slave (
        input hsync, vsync, active, col_count, row_count,
        input line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_axis_timing.sv
// One timing axis: wrapping position counter plus active and sync-window decode.
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL       = DefTotalCols,
    parameter int unsigned ACTIVE      = DefActiveCols,
    parameter int unsigned FRONT_PORCH = DefHFrontPorch,
    parameter int unsigned SYNC_WIDTH  = DefHSyncWidth
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    output logic [CntW-1:0] count,
    output logic            wrap,
    output logic            active_next,
    output logic            sync_pulse
);

    if (TOTAL > MaxTotal || TOTAL == 0) begin : g_bad_total
        $error("vga_axis_timing: TOTAL out of counter range");
    end
    if (ACTIVE + FRONT_PORCH + SYNC_WIDTH > TOTAL) begin : g_bad_window
        $error("vga_axis_timing: active + porch + sync exceeds TOTAL");
    end

    // Window bounds may reach 1024, so decode in one extra bit.
    localparam logic [CntW-1:0] Last      = CntW'(TOTAL - 1);
    localparam logic [CntW:0]   ActEnd    = (CntW + 1)'(ACTIVE);
    localparam logic [CntW:0]   SyncStart = (CntW + 1)'(ACTIVE + FRONT_PORCH);
    localparam logic [CntW:0]   SyncEnd   = (CntW + 1)'(ACTIVE + FRONT_PORCH + SYNC_WIDTH);

    logic [CntW-1:0] count_q, count_d;
    logic [CntW:0]   count_ext;
    logic            sync_q, sync_d;

    assign wrap = advance && (count_q == Last);

    // Next position: increment on advance, wrap after the last position.
    always_comb begin
        count_d = count_q;
        if (advance) begin
            count_d = (count_q == Last) ? '0 : count_q + 1'b1;
        end
    end

    assign count_ext   = {1'b0, count_d};
    assign active_next = count_ext < ActEnd;
    assign sync_d      = (count_ext >= SyncStart) && (count_ext < SyncEnd);

    // Position and sync register; reset parks on the last position of the axis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= Last;
            sync_q  <= 1'b0;
        end else if (advance) begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count      = count_q;
    assign sync_pulse = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, syncs, active flag, line/frame strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS      = DefTotalCols,
    parameter int unsigned TOTAL_ROWS      = DefTotalRows,
    parameter int unsigned ACTIVE_COLS     = DefActiveCols,
    parameter int unsigned ACTIVE_ROWS     = DefActiveRows,
    parameter int unsigned H_FRONT_PORCH   = DefHFrontPorch,
    parameter int unsigned H_SYNC_WIDTH    = DefHSyncWidth,
    parameter int unsigned V_FRONT_PORCH   = DefVFrontPorch,
    parameter int unsigned V_SYNC_WIDTH    = DefVSyncWidth,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Pix_En,
    vga_sync_gen_if.master vga
);

    localparam logic SyncOn = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic            h_wrap, v_wrap;
    logic            h_act_next, v_act_next;
    logic            h_sync_p, v_sync_p;
    logic [CntW-1:0] col, row;

    logic                 active_q;
    logic                 line_start_q;
    logic                 frame_start_q;
    logic [FrameCntW-1:0] frame_cnt_q;

    vga_axis_timing #(
        .TOTAL       (TOTAL_COLS),
        .ACTIVE      (ACTIVE_COLS),
        .FRONT_PORCH (H_FRONT_PORCH),
        .SYNC_WIDTH  (H_SYNC_WIDTH)
    ) u_h_axis (
        .clk         (i_Clk),
        .rst_n       (i_Rst_L),
        .advance     (i_Pix_En),
        .count       (col),
        .wrap        (h_wrap),
        .active_next (h_act_next),
        .sync_pulse  (h_sync_p)
    );

    // Rows step only on the enabled edge that wraps the column.
    vga_axis_timing #(
        .TOTAL       (TOTAL_ROWS),
        .ACTIVE      (ACTIVE_ROWS),
        .FRONT_PORCH (V_FRONT_PORCH),
        .SYNC_WIDTH  (V_SYNC_WIDTH)
    ) u_v_axis (
        .clk         (i_Clk),
        .rst_n       (i_Rst_L),
        .advance     (h_wrap),
        .count       (row),
        .wrap        (v_wrap),
        .active_next (v_act_next),
        .sync_pulse  (v_sync_p)
    );

    // Active flag and strobes registered alongside the counters; strobes clear when idle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '1;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (i_Pix_En) begin
                active_q <= h_act_next & v_act_next;
            end
            if (v_wrap) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign vga.hsync       = h_sync_p ? SyncOn : ~SyncOn;
    assign vga.vsync       = v_sync_p ? SyncOn : ~SyncOn;
    assign vga.active      = active_q;
    assign vga.col_count   = col;
    assign vga.row_count   = row;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a small-geometry instance for frame-level checks, a default one for line checks.
module tb_vga_sync_gen;

    logic clk;
    logic rst_n;
    logic pix_en;

    int n_pass;
    int n_total;

    // Small geometry: 20x10 total, 12x6 active, HSync cols 14..16, VSync rows 7..8.
    vga_sync_gen_if s_if ();
    vga_sync_gen_if d_if ();

    vga_sync_gen #(
        .TOTAL_COLS      (20),
        .TOTAL_ROWS      (10),
        .ACTIVE_COLS     (12),
        .ACTIVE_ROWS     (6),
        .H_FRONT_PORCH   (2),
        .H_SYNC_WIDTH    (3),
        .V_FRONT_PORCH   (1),
        .V_SYNC_WIDTH    (2),
        .SYNC_ACTIVE_LOW (1)
    ) u_small (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_Pix_En (pix_en),
        .vga      (s_if)
    );

    vga_sync_gen u_dflt (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_Pix_En (pix_en),
        .vga      (d_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (2) step();
        n_total++; if (s_if.col_count !== 10'd19) $display("FAIL reset_col got %0d want 19", s_if.col_count); else n_pass++;
        n_total++; if (s_if.row_count !== 10'd9) $display("FAIL reset_row got %0d want 9", s_if.row_count); else n_pass++;
        n_total++; if (s_if.hsync !== 1'b1) $display("FAIL reset_hsync got %b want 1", s_if.hsync); else n_pass++;
        n_total++; if (s_if.vsync !== 1'b1) $display("FAIL reset_vsync got %b want 1", s_if.vsync); else n_pass++;
        n_total++; if (s_if.active !== 1'b0) $display("FAIL reset_active got %b want 0", s_if.active); else n_pass++;
        n_total++; if (s_if.line_start !== 1'b0) $display("FAIL reset_ls got %b want 0", s_if.line_start); else n_pass++;
        n_total++; if (s_if.frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", s_if.frame_start); else n_pass++;
        n_total++; if (s_if.frame_count !== 8'hFF) $display("FAIL reset_fc got %h want ff", s_if.frame_count); else n_pass++;
        n_total++; if (d_if.col_count !== 10'd799) $display("FAIL reset_dcol got %0d want 799", d_if.col_count); else n_pass++;
        n_total++; if (d_if.row_count !== 10'd524) $display("FAIL reset_drow got %0d want 524", d_if.row_count); else n_pass++;
    endtask

    task automatic test_first_edge();
        rst_n = 1'b1;
        step();
        n_total++; if (s_if.col_count !== 10'd0) $display("FAIL first_col got %0d want 0", s_if.col_count); else n_pass++;
        n_total++; if (s_if.row_count !== 10'd0) $display("FAIL first_row got %0d want 0", s_if.row_count); else n_pass++;
        n_total++; if (s_if.active !== 1'b1) $display("FAIL first_active got %b want 1", s_if.active); else n_pass++;
        n_total++; if (s_if.line_start !== 1'b1) $display("FAIL first_ls got %b want 1", s_if.line_start); else n_pass++;
        n_total++; if (s_if.frame_start !== 1'b1) $display("FAIL first_fs got %b want 1", s_if.frame_start); else n_pass++;
        n_total++; if (s_if.frame_count !== 8'h00) $display("FAIL first_fc got %h want 00", s_if.frame_count); else n_pass++;
        n_total++; if (d_if.col_count !== 10'd0 || d_if.row_count !== 10'd0)
            $display("FAIL first_dpos got %0d,%0d want 0,0", d_if.col_count, d_if.row_count); else n_pass++;
        step();
        n_total++; if (s_if.line_start !== 1'b0 || s_if.frame_start !== 1'b0)
            $display("FAIL second_strobes got ls=%b fs=%b want 0,0", s_if.line_start, s_if.frame_start); else n_pass++;
        n_total++; if (s_if.col_count !== 10'd1) $display("FAIL second_col got %0d want 1", s_if.col_count); else n_pass++;
    endtask

    task automatic test_line();
        int lo = 0, first = -1, last = -1, act = 0, alast = -1, col_err = 0;
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            step();
            if (d_if.col_count !== 10'(k)) col_err++;
            if (d_if.hsync === 1'b0) begin
                lo++;
                if (first < 0) first = k;
                last = k;
            end
            if (d_if.active === 1'b1) begin
                act++;
                alast = k;
            end
        end
        n_total++; if (col_err !== 0) $display("FAIL line_cols errors %0d want 0", col_err); else n_pass++;
        n_total++; if (lo !== 96) $display("FAIL line_hs_len got %0d want 96", lo); else n_pass++;
        n_total++; if (first !== 656) $display("FAIL line_hs_first got %0d want 656", first); else n_pass++;
        n_total++; if (last !== 751) $display("FAIL line_hs_last got %0d want 751", last); else n_pass++;
        n_total++; if (act !== 640) $display("FAIL line_active got %0d want 640", act); else n_pass++;
        n_total++; if (alast !== 639) $display("FAIL line_active_last got %0d want 639", alast); else n_pass++;
        step();
        n_total++; if (d_if.row_count !== 10'd1 || d_if.col_count !== 10'd0)
            $display("FAIL line_wrap got %0d,%0d want 0,1", d_if.col_count, d_if.row_count); else n_pass++;
        n_total++; if (d_if.line_start !== 1'b1 || d_if.frame_start !== 1'b0)
            $display("FAIL line_wrap_strobes got ls=%b fs=%b want 1,0", d_if.line_start, d_if.frame_start); else n_pass++;
    endtask

    task automatic test_frame();
        int pos_err = 0, vs_err = 0, vs_lo = 0, hs_lo = 0, act = 0, ls = 0, fs = 0;
        apply_reset();
        for (int k = 0; k < 200; k++) begin
            int ecol, erow;
            logic evs;
            step();
            ecol = k % 20;
            erow = k / 20;
            evs  = !(erow >= 7 && erow <= 8);
            if (s_if.col_count !== 10'(ecol) || s_if.row_count !== 10'(erow)) pos_err++;
            if (s_if.vsync !== evs) vs_err++;
            if (s_if.vsync === 1'b0) vs_lo++;
            if (s_if.hsync === 1'b0) hs_lo++;
            if (s_if.active === 1'b1) act++;
            if (s_if.line_start === 1'b1) ls++;
            if (s_if.frame_start === 1'b1) fs++;
        end
        n_total++; if (pos_err !== 0) $display("FAIL frame_pos errors %0d want 0", pos_err); else n_pass++;
        n_total++; if (vs_err !== 0) $display("FAIL frame_vs_rows errors %0d want 0", vs_err); else n_pass++;
        n_total++; if (vs_lo !== 40) $display("FAIL frame_vs_len got %0d want 40", vs_lo); else n_pass++;
        n_total++; if (hs_lo !== 30) $display("FAIL frame_hs_len got %0d want 30", hs_lo); else n_pass++;
        n_total++; if (act !== 72) $display("FAIL frame_active got %0d want 72", act); else n_pass++;
        n_total++; if (ls !== 10) $display("FAIL frame_ls got %0d want 10", ls); else n_pass++;
        n_total++; if (fs !== 1) $display("FAIL frame_fs got %0d want 1", fs); else n_pass++;
        step();
        n_total++; if (s_if.frame_start !== 1'b1) $display("FAIL frame_next_fs got %b want 1", s_if.frame_start); else n_pass++;
        n_total++; if (s_if.frame_count !== 8'd1) $display("FAIL frame_next_fc got %0d want 1", s_if.frame_count); else n_pass++;
    endtask

    task automatic test_pix_en_toggle();
        int fs_cnt = 0, fs_first = -1, fs_last = -1, hold_err = 0, strobe_err = 0;
        logic [9:0] pcol, prow;
        logic       phs, pvs, pact;
        apply_reset();
        for (int c = 0; c <= 400; c++) begin
            pix_en = (c % 2 == 0);
            pcol = s_if.col_count;
            prow = s_if.row_count;
            phs  = s_if.hsync;
            pvs  = s_if.vsync;
            pact = s_if.active;
            step();
            if (!pix_en) begin
                if (s_if.col_count !== pcol || s_if.row_count !== prow || s_if.hsync !== phs ||
                    s_if.vsync !== pvs || s_if.active !== pact) hold_err++;
                if (s_if.frame_start !== 1'b0 || s_if.line_start !== 1'b0) strobe_err++;
            end
            if (s_if.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                fs_last = c;
            end
        end
        pix_en = 1'b1;
        n_total++; if (fs_cnt !== 2) $display("FAIL toggle_fs_count got %0d want 2", fs_cnt); else n_pass++;
        n_total++; if (fs_first !== 0) $display("FAIL toggle_fs_first got %0d want 0", fs_first); else n_pass++;
        n_total++; if (fs_last !== 400) $display("FAIL toggle_fs_period got %0d want 400", fs_last); else n_pass++;
        n_total++; if (hold_err !== 0) $display("FAIL toggle_hold errors %0d want 0", hold_err); else n_pass++;
        n_total++; if (strobe_err !== 0) $display("FAIL toggle_strobe errors %0d want 0", strobe_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (156) step();
        n_total++; if (s_if.hsync !== 1'b0 || s_if.vsync !== 1'b0)
            $display("FAIL mid_pre_sync got hs=%b vs=%b want 0,0", s_if.hsync, s_if.vsync); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (s_if.col_count !== 10'd19 || s_if.row_count !== 10'd9)
            $display("FAIL mid_pos got %0d,%0d want 19,9", s_if.col_count, s_if.row_count); else n_pass++;
        n_total++; if (s_if.hsync !== 1'b1 || s_if.vsync !== 1'b1)
            $display("FAIL mid_sync got hs=%b vs=%b want 1,1", s_if.hsync, s_if.vsync); else n_pass++;
        n_total++; if (s_if.frame_count !== 8'hFF) $display("FAIL mid_fc got %h want ff", s_if.frame_count); else n_pass++;
        n_total++; if (d_if.col_count !== 10'd799 || d_if.row_count !== 10'd524)
            $display("FAIL mid_dpos got %0d,%0d want 799,524", d_if.col_count, d_if.row_count); else n_pass++;
        n_total++; if (d_if.active !== 1'b0) $display("FAIL mid_dactive got %b want 0", d_if.active); else n_pass++;
    endtask

    task automatic test_frame_count();
        int fs_seen = 0, seq_err = 0;
        apply_reset();
        for (int k = 0; k <= 256 * 200; k++) begin
            step();
            if (s_if.frame_start === 1'b1) begin
                if (s_if.frame_count !== fs_seen[7:0]) seq_err++;
                fs_seen++;
            end
        end
        n_total++; if (fs_seen !== 257) $display("FAIL fc_frames got %0d want 257", fs_seen); else n_pass++;
        n_total++; if (seq_err !== 0) $display("FAIL fc_sequence errors %0d want 0", seq_err); else n_pass++;
        n_total++; if (s_if.frame_count !== 8'd0) $display("FAIL fc_wrap got %0d want 0", s_if.frame_count); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        pix_en  = 1'b0;
        test_reset();
        test_first_edge();
        test_line();
        test_frame();
        test_pix_en_toggle();
        test_reset_mid();
        test_frame_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
